pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 40 ++++
 rtl/pc_sequencer_return_stack.sv | 62 ++++++
 rtl/pc_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared opcode constants, decode helper and default widths for the program-counter sequencer.
package pc_sequencer_pkg;

  localparam int unsigned PC_W_DEFAULT     = 10;
  localparam int unsigned RS_DEPTH_DEFAULT = 4;
  localparam int unsigned OPC_W            = 6;

  localparam logic [OPC_W-1:0] OPC_J    = 6'b111100;
  localparam logic [OPC_W-1:0] OPC_JZ   = 6'b111101;
  localparam logic [OPC_W-1:0] OPC_JNZ  = 6'b111110;
  localparam logic [OPC_W-1:0] OPC_RSV  = 6'b111111;
  localparam logic [OPC_W-1:0] OPC_CALL = 6'b111000;
  localparam logic [OPC_W-1:0] OPC_RET  = 6'b111001;

  typedef enum logic [2:0] {
    OP_SEQ,
    OP_INC,
    OP_J,
    OP_JZ,
    OP_JNZ,
    OP_CALL,
    OP_RET
  } op_class_e;

  // Unassigned codes in the 1110xx/1111xx space ignore s_inc and always advance.
  function automatic op_class_e decode_op(input logic [OPC_W-1:0] opcode);
    op_class_e cls;
    case (opcode)
      OPC_J:    cls = OP_J;
      OPC_JZ:   cls = OP_JZ;
      OPC_JNZ:  cls = OP_JNZ;
      OPC_RSV:  cls = OP_INC;
      OPC_CALL: cls = OP_CALL;
      OPC_RET:  cls = OP_RET;
      default:  cls = (opcode[5:3] == 3'b111) ? OP_INC : OP_SEQ;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Return-address stack: push/pop with registered top-of-stack, full and empty status.
module return_stack
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEFAULT,
  parameter int unsigned RS_DEPTH = RS_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] data_in,
  output logic [PC_W-1:0] data_out,
  output logic            full,
  output logic            empty
);

  localparam int unsigned IDX_W = $clog2(RS_DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [PC_W-1:0]  mem [RS_DEPTH];
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Push wins if both are requested; a push on a full stack is dropped.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !do_push;

  // Entry storage is never reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[count[IDX_W-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (do_push) begin
      count <= count + CNT_W'(1);
      full  <= (count == CNT_W'(RS_DEPTH - 1));
      empty <= 1'b0;
    end else if (do_pop) begin
      count <= count - CNT_W'(1);
      full  <= 1'b0;
      empty <= (count == CNT_W'(1));
    end
  end

  // Top-of-stack copy kept in a register so the pc mux sees it with no read delay.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_out <= data_in;
    end else if (do_pop && (count >= CNT_W'(2))) begin
      data_out <= mem[IDX_W'(count - CNT_W'(2))];
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-pc mux, pc and zero-flag registers, return stack and sticky stack errors.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W     = PC_W_DEFAULT,
  parameter int unsigned RS_DEPTH = RS_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic [PC_W-1:0]  target,
  input  logic             s_inc,
  input  logic             alu_zero,
  input  logic             z_we,
  output logic [PC_W-1:0]  pc,
  output logic             z_flag,
  output logic             rs_ovf,
  output logic             rs_unf
);

  op_class_e       op_class;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] rs_top;
  logic            rs_push;
  logic            rs_pop;
  logic            rs_full;
  logic            rs_empty;
  logic            set_ovf;
  logic            set_unf;

  assign op_class = decode_op(opcode);
  assign pc_inc   = pc + PC_W'(1);

  // Next-pc selection; conditionals use the flag value held before this edge.
  always_comb begin
    pc_next = pc;
    rs_push = 1'b0;
    rs_pop  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    case (op_class)
      OP_SEQ:  pc_next = s_inc ? pc_inc : pc;
      OP_INC:  pc_next = pc_inc;
      OP_J:    pc_next = target;
      OP_JZ:   pc_next = z_flag ? target : pc_inc;
      OP_JNZ:  pc_next = z_flag ? pc_inc : target;
      OP_CALL: begin
        pc_next = target;
        rs_push = 1'b1;
        set_ovf = rs_full;
      end
      OP_RET: begin
        if (rs_empty) begin
          pc_next = pc_inc;
          set_unf = 1'b1;
        end else begin
          pc_next = rs_top;
          rs_pop  = 1'b1;
        end
      end
      default: pc_next = pc;
    endcase
  end

  return_stack #(
    .PC_W     (PC_W),
    .RS_DEPTH (RS_DEPTH)
  ) u_return_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (rs_push),
    .pop      (rs_pop),
    .data_in  (pc_inc),
    .data_out (rs_top),
    .full     (rs_full),
    .empty    (rs_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      z_flag <= 1'b0;
      rs_ovf <= 1'b0;
      rs_unf <= 1'b0;
    end else begin
      pc <= pc_next;
      if (z_we) begin
        z_flag <= alu_zero;
      end
      if (set_ovf) begin
        rs_ovf <= 1'b1;
      end
      if (set_unf) begin
        rs_unf <= 1'b1;
      end
    end
  end

endmodule
